// File: rtl/mmr_bus_if.sv
// CPU memory-stage to MMR responder bus: request/ready handshake plus one-cycle ack response.
interface mmr_bus_if #(
  parameter int RSZ  = 32,
  parameter int PASZ = 32
) ();
  logic            mmr_req;
  logic            mmr_req_ready;
  logic            mmr_we;
  logic [PASZ-1:0] mmr_addr;
  logic [RSZ-1:0]  mmr_wdata;
  logic            mmr_ack;
  logic [RSZ-1:0]  mmr_rdata;
  logic            mmr_err;

  modport master (
    output mmr_req, mmr_we, mmr_addr, mmr_wdata,
    input  mmr_req_ready, mmr_ack, mmr_rdata, mmr_err
  );

  modport slave (
    input  mmr_req, mmr_we, mmr_addr, mmr_wdata,
    output mmr_req_ready, mmr_ack, mmr_rdata, mmr_err
  );
endinterface

// File: rtl/mmr_bus_ctrl.sv
// Bus responder for the machine-mode timer/software-interrupt registers; one access per three cycles,
// with a high-half snapshot so an RV32 lo-then-hi read of mtime is consistent across a carry.
module mmr_bus_ctrl #(
  parameter int          RSZ          = 32,
  parameter int          PASZ         = 32,
  parameter logic [31:0] MMR_BASE     = 32'h0200_0000,
  parameter logic [31:0] MMR_SIZE     = 32'h0001_0000,
  parameter logic [15:0] MSIP_OFF     = 16'h0000,
  parameter logic [15:0] MTIMECMP_OFF = 16'h4000,
  parameter logic [15:0] MTIME_OFF    = 16'hBFF8
) (
  input  logic             clk_in,
  input  logic             reset_in,
  mmr_bus_if.slave         bus,
  output logic             mtime_lo_wr,
  output logic             mtime_hi_wr,
  output logic             mtimecmp_lo_wr,
  output logic             mtimecmp_hi_wr,
  output logic             msip_wr,
  output logic [RSZ-1:0]   mmr_wr_data,
  input  logic [2*RSZ-1:0] mtime,
  input  logic [2*RSZ-1:0] mtimecmp,
  input  logic [RSZ-1:0]   msip_reg
);

  localparam logic [PASZ-1:0] BASE_A = PASZ'(MMR_BASE);
  localparam logic [PASZ-1:0] SIZE_A = PASZ'(MMR_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_RESP} state_t;
  typedef enum logic [2:0] {SEL_NONE, SEL_MSIP, SEL_CMP_LO, SEL_CMP_HI, SEL_MT_LO, SEL_MT_HI} sel_t;

  // Any misaligned, out-of-window or unmapped address maps to SEL_NONE and faults.
  function automatic sel_t decode_sel(input logic [PASZ-1:0] addr);
    logic [PASZ-1:0] off;
    off = addr - BASE_A;
    if (addr[1:0] != 2'b00 || addr < BASE_A || off >= SIZE_A) return SEL_NONE;
    if (off == PASZ'(MSIP_OFF))             return SEL_MSIP;
    if (off == PASZ'(MTIMECMP_OFF))         return SEL_CMP_LO;
    if (off == PASZ'(MTIMECMP_OFF) + 'd4)   return SEL_CMP_HI;
    if (off == PASZ'(MTIME_OFF))            return SEL_MT_LO;
    if (off == PASZ'(MTIME_OFF) + 'd4)      return SEL_MT_HI;
    return SEL_NONE;
  endfunction

  state_t          state, state_nx;
  logic            we_p0;
  logic [PASZ-1:0] addr_p0;
  sel_t            sel_p0;
  logic [RSZ-1:0]  rdata_q;
  logic            err_q;
  logic            snap_vld;
  logic [RSZ-1:0]  snap_hi;
  logic            accept;

  assign accept = (state == S_IDLE) && bus.mmr_req;
  assign sel_p0 = decode_sel(addr_p0);

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) state <= S_IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx          = state;
    bus.mmr_req_ready = 1'b0;
    bus.mmr_ack       = 1'b0;
    msip_wr           = 1'b0;
    mtimecmp_lo_wr    = 1'b0;
    mtimecmp_hi_wr    = 1'b0;
    mtime_lo_wr       = 1'b0;
    mtime_hi_wr       = 1'b0;
    case (state)
      S_IDLE: begin
        bus.mmr_req_ready = 1'b1;
        if (bus.mmr_req) state_nx = S_DECODE;
      end
      S_DECODE: begin
        msip_wr        = we_p0 && (sel_p0 == SEL_MSIP);
        mtimecmp_lo_wr = we_p0 && (sel_p0 == SEL_CMP_LO);
        mtimecmp_hi_wr = we_p0 && (sel_p0 == SEL_CMP_HI);
        mtime_lo_wr    = we_p0 && (sel_p0 == SEL_MT_LO);
        mtime_hi_wr    = we_p0 && (sel_p0 == SEL_MT_HI);
        state_nx       = S_RESP;
      end
      S_RESP: begin
        bus.mmr_ack = 1'b1;
        state_nx    = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Request capture stage: later bus changes cannot disturb an accepted access.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      we_p0   <= bus.mmr_we;
      addr_p0 <= bus.mmr_addr;
    end
  end

  // Decode stage: read mux, fault flag and mtime snapshot bookkeeping.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      mmr_wr_data <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      snap_vld    <= 1'b0;
      snap_hi     <= '0;
    end else begin
      if (accept && bus.mmr_we) mmr_wr_data <= bus.mmr_wdata;
      if (state == S_DECODE) begin
        err_q   <= (sel_p0 == SEL_NONE);
        rdata_q <= '0;
        if (we_p0) begin
          if (sel_p0 == SEL_MT_LO || sel_p0 == SEL_MT_HI) snap_vld <= 1'b0;
        end else begin
          case (sel_p0)
            SEL_MSIP:   rdata_q <= msip_reg;
            SEL_CMP_LO: rdata_q <= mtimecmp[RSZ-1:0];
            SEL_CMP_HI: rdata_q <= mtimecmp[2*RSZ-1:RSZ];
            SEL_MT_LO: begin
              rdata_q  <= mtime[RSZ-1:0];
              snap_hi  <= mtime[2*RSZ-1:RSZ];
              snap_vld <= 1'b1;
            end
            SEL_MT_HI: begin
              rdata_q  <= snap_vld ? snap_hi : mtime[2*RSZ-1:RSZ];
              snap_vld <= 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.mmr_rdata = rdata_q;
  assign bus.mmr_err   = err_q && (state == S_RESP);

endmodule

// File: tb/tb_mmr_bus_ctrl.sv
// Randomized self-checking bench for mmr_bus_ctrl; the bench also plays the irq register block.
module tb_mmr_bus_ctrl;
  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [31:0] SIZE = 32'h0001_0000;
  localparam logic [31:0] ADDRS [0:9] = '{32'h0200_0000, 32'h0200_4000, 32'h0200_4004,
                                          32'h0200_BFF8, 32'h0200_BFFC, 32'h0200_0002,
                                          32'h0200_1000, 32'h0300_0000, 32'h0200_FFFC,
                                          32'h01FF_FFFC};

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b0;
  logic        mtime_lo_wr, mtime_hi_wr, mtimecmp_lo_wr, mtimecmp_hi_wr, msip_wr;
  logic [31:0] mmr_wr_data;
  logic [63:0] mtime, mtimecmp;
  logic [31:0] msip_reg;
  logic [4:0]  stb;

  int checks = 0;
  int errors = 0;

  // Reference snapshot state: what a correct responder remembers after an mtime lo load.
  bit          snap_ok;
  logic [31:0] snap_val;

  mmr_bus_if #(.RSZ(32), .PASZ(32)) bus ();

  mmr_bus_ctrl dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .bus            (bus),
    .mtime_lo_wr    (mtime_lo_wr),
    .mtime_hi_wr    (mtime_hi_wr),
    .mtimecmp_lo_wr (mtimecmp_lo_wr),
    .mtimecmp_hi_wr (mtimecmp_hi_wr),
    .msip_wr        (msip_wr),
    .mmr_wr_data    (mmr_wr_data),
    .mtime          (mtime),
    .mtimecmp       (mtimecmp),
    .msip_reg       (msip_reg)
  );

  assign stb = {msip_wr, mtimecmp_lo_wr, mtimecmp_hi_wr, mtime_lo_wr, mtime_hi_wr};

  always #5 clk_in = ~clk_in;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Strobe vector order: {msip, cmp_lo, cmp_hi, mtime_lo, mtime_hi}.
  task automatic predict(input logic we, input logic [31:0] addr,
                         output logic [4:0] e_stb, output logic e_err, output logic [31:0] e_rd);
    logic [31:0] off;
    e_stb = 5'b0; e_err = 1'b0; e_rd = 32'h0;
    off = addr - BASE;
    if ((addr % 4) != 0 || addr < BASE || addr >= BASE + SIZE) begin
      e_err = 1'b1;
    end else begin
      case (off)
        32'h0000: if (we) e_stb = 5'b10000; else e_rd = msip_reg;
        32'h4000: if (we) e_stb = 5'b01000; else e_rd = mtimecmp[31:0];
        32'h4004: if (we) e_stb = 5'b00100; else e_rd = mtimecmp[63:32];
        32'hBFF8: if (we) begin e_stb = 5'b00010; snap_ok = 0; end
                  else begin e_rd = mtime[31:0]; snap_val = mtime[63:32]; snap_ok = 1; end
        32'hBFFC: if (we) begin e_stb = 5'b00001; snap_ok = 0; end
                  else begin e_rd = snap_ok ? snap_val : mtime[63:32]; snap_ok = 0; end
        default:  e_err = 1'b1;
      endcase
    end
  endtask

  // Starts and ends on a falling edge; checks strobe cycle and ack cycle against the model.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input string tag, output logic [31:0] rd);
    logic [4:0]  e_stb;
    logic        e_err;
    logic [31:0] e_rd;
    int          n;
    predict(we, addr, e_stb, e_err, e_rd);
    bus.mmr_req = 1'b1; bus.mmr_we = we; bus.mmr_addr = addr; bus.mmr_wdata = wdata;
    n = 0;
    while (!bus.mmr_req_ready && n < 10) begin @(negedge clk_in); n++; end
    checks++;
    if (!bus.mmr_req_ready) begin
      errors++;
      $display("FAIL %s/ready_timeout: ready=%b required 1", tag, bus.mmr_req_ready);
      bus.mmr_req = 1'b0; rd = 32'h0;
      return;
    end
    @(posedge clk_in); #1;
    bus.mmr_req = 1'b0; bus.mmr_we = $urandom; bus.mmr_addr = $urandom; bus.mmr_wdata = $urandom;
    @(negedge clk_in);
    checks++;
    if (stb !== e_stb) begin errors++; $display("FAIL %s/strobe: got %b required %b", tag, stb, e_stb); end
    checks++;
    if (bus.mmr_ack !== 1'b0) begin errors++; $display("FAIL %s/early_ack: got %b required 0", tag, bus.mmr_ack); end
    if (we) begin
      checks++;
      if (mmr_wr_data !== wdata) begin errors++; $display("FAIL %s/wr_data: got %h required %h", tag, mmr_wr_data, wdata); end
    end
    if (stb[4]) msip_reg = mmr_wr_data;
    if (stb[3]) mtimecmp[31:0] = mmr_wr_data;
    if (stb[2]) mtimecmp[63:32] = mmr_wr_data;
    if (stb[1]) mtime[31:0] = mmr_wr_data;
    if (stb[0]) mtime[63:32] = mmr_wr_data;
    @(negedge clk_in);
    checks++;
    if (bus.mmr_ack !== 1'b1) begin errors++; $display("FAIL %s/ack: got %b required 1", tag, bus.mmr_ack); end
    checks++;
    if (bus.mmr_err !== e_err) begin errors++; $display("FAIL %s/err: got %b required %b", tag, bus.mmr_err, e_err); end
    if (!we || e_err) begin
      checks++;
      if (bus.mmr_rdata !== e_rd) begin errors++; $display("FAIL %s/rdata: got %h required %h", tag, bus.mmr_rdata, e_rd); end
    end
    checks++;
    if (stb !== 5'b0) begin errors++; $display("FAIL %s/strobe_in_resp: got %b required 00000", tag, stb); end
    rd = bus.mmr_rdata;
  endtask

  task automatic test_reset();
    reset_in = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    checks++;
    if (bus.mmr_req_ready !== 1'b1) begin errors++; $display("FAIL reset/ready: got %b required 1", bus.mmr_req_ready); end
    checks++;
    if ({bus.mmr_ack, bus.mmr_err} !== 2'b00) begin errors++; $display("FAIL reset/ack_err: got %b required 00", {bus.mmr_ack, bus.mmr_err}); end
    checks++;
    if (bus.mmr_rdata !== 32'h0 || mmr_wr_data !== 32'h0) begin
      errors++; $display("FAIL reset/data: got rdata %h wr_data %h required 0 0", bus.mmr_rdata, mmr_wr_data);
    end
    checks++;
    if (stb !== 5'b0) begin errors++; $display("FAIL reset/strobes: got %b required 00000", stb); end
    reset_in = 1'b1;
    snap_ok = 0;
    @(negedge clk_in);
  endtask

  task automatic test_post_reset_store();
    logic [31:0] rd;
    access(1'b1, 32'h0200_0000, 32'h0000_0001, "msip_store", rd);
    checks++;
    if (msip_reg !== 32'h1) begin errors++; $display("FAIL msip_store/reg: got %h required 00000001", msip_reg); end
  endtask

  task automatic test_mtimecmp();
    logic [31:0] rd;
    access(1'b1, 32'h0200_4000, 32'h0000_1000, "cmp_lo_store", rd);
    access(1'b1, 32'h0200_4004, 32'h0000_0000, "cmp_hi_store", rd);
    access(1'b0, 32'h0200_4000, 32'h0, "cmp_lo_load", rd);
    checks++;
    if (rd !== 32'h0000_1000) begin errors++; $display("FAIL cmp_lo_load/value: got %h required 00001000", rd); end
    access(1'b0, 32'h0200_4004, 32'h0, "cmp_hi_load", rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL cmp_hi_load/value: got %h required 00000000", rd); end
  endtask

  task automatic test_snapshot_carry();
    logic [31:0] rd;
    mtime = 64'h0000_0001_FFFF_FFFF;
    access(1'b0, 32'h0200_BFF8, 32'h0, "snap_lo", rd);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL snap_lo/value: got %h required ffffffff", rd); end
    mtime = 64'h0000_0002_0000_0005;
    access(1'b0, 32'h0200_BFFC, 32'h0, "snap_hi", rd);
    checks++;
    if (rd !== 32'h0000_0001) begin errors++; $display("FAIL snap_hi/value: got %h required 00000001", rd); end
    access(1'b0, 32'h0200_BFFC, 32'h0, "live_hi", rd);
    checks++;
    if (rd !== 32'h0000_0002) begin errors++; $display("FAIL live_hi/value: got %h required 00000002", rd); end
  endtask

  task automatic test_snapshot_invalidate();
    logic [31:0] rd;
    mtime = 64'h0000_00AA_1234_5678;
    access(1'b0, 32'h0200_BFF8, 32'h0, "inval_lo", rd);
    access(1'b1, 32'h0200_BFFC, 32'h0000_0007, "inval_store", rd);
    access(1'b0, 32'h0200_BFFC, 32'h0, "inval_hi", rd);
    checks++;
    if (rd !== 32'h0000_0007) begin errors++; $display("FAIL inval_hi/value: got %h required 00000007", rd); end
  endtask

  task automatic test_faults();
    logic [31:0] rd;
    access(1'b1, 32'h0200_0002, 32'hDEAD_BEEF, "fault_misaligned", rd);
    access(1'b0, 32'h0200_1000, 32'h0, "fault_unmapped", rd);
    access(1'b0, 32'h0300_0000, 32'h0, "fault_outside", rd);
    access(1'b1, 32'h0200_FFFC, 32'h1234_0000, "fault_store_unmapped", rd);
  endtask

  task automatic test_back_to_back();
    logic [8:0] got, exp;
    @(negedge clk_in);
    msip_reg = 32'hA5A5_0003;
    bus.mmr_req = 1'b1; bus.mmr_we = 1'b0; bus.mmr_addr = 32'h0200_0000;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_in);
      got[i] = bus.mmr_ack;
      exp[i] = (i % 3 == 1);
      if (bus.mmr_ack) begin
        checks++;
        if (bus.mmr_rdata !== msip_reg) begin errors++; $display("FAIL b2b/rdata: got %h required %h", bus.mmr_rdata, msip_reg); end
      end
    end
    bus.mmr_req = 1'b0;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL b2b/ack_pattern: got %b required %b", got, exp); end
    @(negedge clk_in); @(negedge clk_in);
  endtask

  task automatic test_random();
    logic [31:0] rd;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(2, 0) == 0) mtime = {$urandom, $urandom};
      if ($urandom_range(3, 0) == 0) begin
        mtimecmp = {$urandom, $urandom};
        msip_reg = $urandom;
      end
      access(1'($urandom), ADDRS[$urandom_range(9, 0)], $urandom, "random", rd);
      repeat ($urandom_range(2, 0)) @(negedge clk_in);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd;
    mtime = 64'h0000_0011_0000_0022;
    access(1'b0, 32'h0200_BFF8, 32'h0, "midop_lo", rd);
    mtime = 64'h0000_0033_0000_0044;
    @(negedge clk_in);
    bus.mmr_req = 1'b1; bus.mmr_we = 1'b1; bus.mmr_addr = 32'h0200_BFF8; bus.mmr_wdata = 32'h55;
    @(posedge clk_in); #1;
    bus.mmr_req = 1'b0;
    @(negedge clk_in);
    checks++;
    if (stb !== 5'b00010) begin errors++; $display("FAIL midop/strobe_before: got %b required 00010", stb); end
    reset_in = 1'b0;
    #1;
    checks++;
    if (stb !== 5'b0 || bus.mmr_ack !== 1'b0) begin
      errors++; $display("FAIL midop/reset_drop: got strobes %b ack %b required 00000 0", stb, bus.mmr_ack);
    end
    repeat (2) @(negedge clk_in);
    checks++;
    if (bus.mmr_ack !== 1'b0) begin errors++; $display("FAIL midop/ack_in_reset: got %b required 0", bus.mmr_ack); end
    reset_in = 1'b1;
    snap_ok = 0;
    #1;
    checks++;
    if (bus.mmr_req_ready !== 1'b1) begin errors++; $display("FAIL midop/ready_after: got %b required 1", bus.mmr_req_ready); end
    access(1'b0, 32'h0200_BFFC, 32'h0, "midop_hi", rd);
    checks++;
    if (rd !== 32'h0000_0033) begin errors++; $display("FAIL midop_hi/value: got %h required 00000033", rd); end
  endtask

  initial begin
    bus.mmr_req = 1'b0; bus.mmr_we = 1'b0; bus.mmr_addr = 32'h0; bus.mmr_wdata = 32'h0;
    mtime = 64'h0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; msip_reg = 32'h0;
    snap_ok = 0; snap_val = 32'h0;
    test_reset();
    test_post_reset_store();
    test_mtimecmp();
    test_snapshot_carry();
    test_snapshot_invalidate();
    test_faults();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmr_bus_ctrl.md
Name: mmr_bus_ctrl

Overview:
- Bus-side responder for the machine-mode memory-mapped timer/software-interrupt registers.
- Accepts word load/store requests from the CPU memory stage via a ready/ack handshake.
- Decodes the address and drives one-cycle write strobes plus `mmr_wr_data` into the irq register block.
- Returns read data sampled from that block's `mtime`, `mtimecmp` and `msip_reg` outputs, and provides a consistent 64-bit `mtime` read on the RV32 bus using a high-half snapshot.

Parameters:
- RSZ, 32, register/data width.
- PASZ, 32, physical address width.
- MMR_BASE, 32'h0200_0000, base address of the MMR window.
- MMR_SIZE, 32'h0001_0000, window size in bytes.
- MSIP_OFF, 16'h0000, offset of msip.
- MTIMECMP_OFF, 16'h4000, offset of mtimecmp lo (hi at +4).
- MTIME_OFF, 16'hBFF8, offset of mtime lo (hi at +4).

Ports:
- clk_in  input  1  clock.
- reset_in  input  1  asynchronous active-low reset.
- mmr_req  input  1  request valid.
- mmr_req_ready  output  1  request accepted when mmr_req & mmr_req_ready.
- mmr_we  input  1  1=store, 0=load.
- mmr_addr  input  PASZ  byte address.
- mmr_wdata  input  RSZ  store data.
- mmr_ack  output  1  one-cycle completion pulse.
- mmr_rdata  output  RSZ  load data, valid while mmr_ack=1.
- mmr_err  output  1  access fault, valid while mmr_ack=1.
- mtime_lo_wr  output  1  write strobe.
- mtime_hi_wr  output  1  write strobe.
- mtimecmp_lo_wr  output  1  write strobe.
- mtimecmp_hi_wr  output  1  write strobe.
- msip_wr  output  1  write strobe.
- mmr_wr_data  output  RSZ  write data for strobes.
- mtime  input  2*RSZ  live timer.
- mtimecmp  input  2*RSZ  compare value.
- msip_reg  input  RSZ  msip register.

Behaviour:
- **Reset (async, reset_in=0):** state=IDLE. All strobes, mmr_ack, mmr_err=0. mmr_rdata=0, mmr_wr_data=0. Snapshot valid (snap_vld)=0, snap_hi=0. An in-flight request is dropped with no ack.
- **FSM states:** IDLE, DECODE, RESP.
- **IDLE:** mmr_req_ready=1 (combinational, ready=1 only in IDLE). On accept, latch we/addr/wdata and go to DECODE.
- **DECODE:** exactly one cycle.
  - Hit requires addr[1:0]==0 and MMR_BASE <= addr < MMR_BASE+MMR_SIZE; offset = addr-MMR_BASE.
  - Store hit: assert the single matching strobe for this cycle only, with mmr_wr_data = latched wdata. mmr_wr_data holds that value until the next accepted store.
  - Load hit: register the selected data into mmr_rdata (see mtime rules).
    - msip returns msip_reg.
    - mtimecmp lo/hi return mtimecmp[RSZ-1:0] / [2*RSZ-1:RSZ].
  - Miss (misaligned, out of window, or unmapped offset): no strobe, mmr_rdata=0, set the err flag.
  - Next state: RESP.
- **RESP:** mmr_ack=1 and mmr_err valid for exactly one cycle, then IDLE.
- **Latency and throughput:** accept at cycle N gives strobe at N+1 and ack at N+2. Next accept is possible at N+3, i.e. one access per 3 cycles.
- **mtime lo load:** return mtime[RSZ-1:0] sampled in DECODE; in the same cycle snap_hi<=mtime[2*RSZ-1:RSZ] and snap_vld<=1.
- **mtime hi load:**
  - If snap_vld: return snap_hi and clear snap_vld.
  - Else: return live mtime[2*RSZ-1:RSZ].
- **Snapshot invalidation:** a store to mtime lo or hi clears snap_vld in DECODE. Other accesses leave snap_vld unchanged.
- **Stores to read-only or unmapped offsets:** err=1, no strobe.
- **Request held during non-IDLE states:** mmr_req asserted outside IDLE is ignored and must be held by the requester until accepted. mmr_addr/mmr_wdata changes after acceptance have no effect.
- **Strobe exclusivity:** at most one strobe is high in any cycle, never two.

Test Plan:
- **Post-reset store:** reset_in low 3 cycles then high; store 32'h0000_0001 to 32'h0200_0000.
  - Required: msip_wr=1 for exactly 1 cycle at accept+1 with mmr_wr_data=1; mmr_ack at accept+2 with mmr_err=0.
- **mtimecmp store:** store 32'h0000_1000 to 32'h0200_4000, then 32'h0 to 32'h0200_4004.
  - Required: mtimecmp_lo_wr then mtimecmp_hi_wr, each a single-cycle pulse.
  - Required: loads of both addresses return 32'h0000_1000 and 32'h0.
- **Snapshot across lo carry:** drive mtime=64'h0000_0001_FFFF_FFFF; load 32'h0200_BFF8; change mtime to 64'h0000_0002_0000_0005; load 32'h0200_BFFC.
  - Required: lo=32'hFFFF_FFFF, hi=32'h0000_0001 (snapshot).
  - Required: a second hi load returns 32'h0000_0002 (live).
- **Snapshot invalidation by store:** load mtime lo, store 32'h7 to 32'h0200_BFFC, then load mtime hi.
  - Required: mtime_hi_wr pulse; the hi load returns the live input, not the snapshot.
- **Faults:** store to 32'h0200_0002; load from 32'h0200_1000; load from 32'h0300_0000.
  - Required: each acks with mmr_err=1, mmr_rdata=0, and no strobe.
- **Reset mid-operation:** assert reset_in low during DECODE of a store to mtime lo.
  - Required: strobe and ack deassert immediately; after release, mmr_req_ready=1 and snap_vld=0 (next hi load returns live).
